// File: rtl/if_id_fetch_queue.sv
// IF/ID fetch queue: circular buffer of fetch bundles between fetch and decode.
// Decode may take a prefix of the head bundle; the remaining lanes shift down to lane 0.
module if_id_fetch_queue #(
    parameter int unsigned          LANES     = 2,
    parameter int unsigned          DEPTH     = 4,
    parameter int unsigned          DATA_W    = 16,
    parameter logic [DATA_W-1:0]    NOP_INSTR = 16'hFFFF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES-1:0]              in_lane_valid,
    input  logic [LANES*DATA_W-1:0]       in_pc,
    input  logic [LANES*DATA_W-1:0]       in_pc_plus1,
    input  logic [LANES*DATA_W-1:0]       in_instr,
    output logic                          out_valid,
    output logic [LANES-1:0]              out_lane_valid,
    output logic [LANES*DATA_W-1:0]       out_pc,
    output logic [LANES*DATA_W-1:0]       out_pc_plus1,
    output logic [LANES*DATA_W-1:0]       out_instr,
    input  logic [$clog2(LANES+1)-1:0]    out_consume,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int unsigned CW = $clog2(LANES + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned NW = $clog2(DEPTH + 1);

    logic [LANES-1:0]        valid_q [DEPTH];
    logic [LANES*DATA_W-1:0] pc_q    [DEPTH];
    logic [LANES*DATA_W-1:0] pcp1_q  [DEPTH];
    logic [LANES*DATA_W-1:0] instr_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_nxt, rd_ptr_nxt;
    logic [NW-1:0] count_q, count_d;

    logic [LANES-1:0]        head_valid, sh_valid;
    logic [LANES*DATA_W-1:0] head_pc, head_pcp1, head_instr;
    logic [LANES*DATA_W-1:0] sh_pc, sh_pcp1, sh_instr;
    logic [CW-1:0]           head_lanes, take;
    logic                    push, pop, shift;

    assign in_ready  = (count_q < NW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid && in_ready && (|in_lane_valid);

    assign head_valid = valid_q[rd_ptr_q];
    assign head_pc    = pc_q[rd_ptr_q];
    assign head_pcp1  = pcp1_q[rd_ptr_q];
    assign head_instr = instr_q[rd_ptr_q];

    assign wr_ptr_nxt = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    assign rd_ptr_nxt = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;

    // Lanes decode actually takes: consume clamped to LANES and to the valid head lanes.
    always_comb begin
        head_lanes = '0;
        for (int i = 0; i < LANES; i++) begin
            head_lanes = head_lanes + CW'(head_valid[i]);
        end
        take = (out_consume > CW'(LANES)) ? CW'(LANES) : out_consume;
        if (take > head_lanes) take = head_lanes;
        if (!out_valid) take = '0;
    end

    assign pop   = (take != '0) && (take == head_lanes);
    assign shift = (take != '0) && !pop;

    // Head entry with the first `take` lanes removed and the rest moved down.
    always_comb begin
        sh_valid = '0;
        sh_pc    = '0;
        sh_pcp1  = '0;
        sh_instr = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < LANES; j++) begin
                if (i + int'(take) == j) begin
                    sh_valid[i]                = head_valid[j];
                    sh_pc[i*DATA_W +: DATA_W]    = head_pc[j*DATA_W +: DATA_W];
                    sh_pcp1[i*DATA_W +: DATA_W]  = head_pcp1[j*DATA_W +: DATA_W];
                    sh_instr[i*DATA_W +: DATA_W] = head_instr[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Output lanes: empty queue or invalid lanes read as PC 0 / NOP.
    always_comb begin
        out_lane_valid = '0;
        out_pc         = '0;
        out_pc_plus1   = '0;
        out_instr      = '0;
        for (int i = 0; i < LANES; i++) begin
            if (out_valid && head_valid[i]) begin
                out_lane_valid[i]             = 1'b1;
                out_pc[i*DATA_W +: DATA_W]       = head_pc[i*DATA_W +: DATA_W];
                out_pc_plus1[i*DATA_W +: DATA_W] = head_pcp1[i*DATA_W +: DATA_W];
                out_instr[i*DATA_W +: DATA_W]    = head_instr[i*DATA_W +: DATA_W];
            end else begin
                out_instr[i*DATA_W +: DATA_W]    = NOP_INSTR;
            end
        end
    end

    assign count_d = count_q + NW'(push) - NW'(pop);

    // Queue state: reset/flush clear everything, otherwise push at tail and pop/shift the head.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                valid_q[d] <= '0;
            end
        end else begin
            // wr_ptr never equals rd_ptr while both a push and a head update happen.
            if (push) begin
                valid_q[wr_ptr_q] <= in_lane_valid;
                pc_q[wr_ptr_q]    <= in_pc;
                pcp1_q[wr_ptr_q]  <= in_pc_plus1;
                instr_q[wr_ptr_q] <= in_instr;
                wr_ptr_q          <= wr_ptr_nxt;
            end
            if (pop) begin
                valid_q[rd_ptr_q] <= '0;
                rd_ptr_q          <= rd_ptr_nxt;
            end else if (shift) begin
                valid_q[rd_ptr_q] <= sh_valid;
                pc_q[rd_ptr_q]    <= sh_pc;
                pcp1_q[rd_ptr_q]  <= sh_pcp1;
                instr_q[rd_ptr_q] <= sh_instr;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Randomised and directed bench for if_id_fetch_queue against a lane-level queue model.
module tb_if_id_fetch_queue;

    localparam int unsigned LANES = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = 16;
    localparam logic [W-1:0] NOP  = 16'hFFFF;
    localparam int unsigned CW    = $clog2(LANES + 1);
    localparam int unsigned NW    = $clog2(DEPTH + 1);

    logic                 clock = 1'b0;
    logic                 reset, flush, in_valid, in_ready, out_valid;
    logic [LANES-1:0]     in_lane_valid, out_lane_valid;
    logic [LANES*W-1:0]   in_pc, in_pc_plus1, in_instr;
    logic [LANES*W-1:0]   out_pc, out_pc_plus1, out_instr;
    logic [CW-1:0]        out_consume;
    logic [NW-1:0]        count;

    int checks = 0;
    int errors = 0;

    if_id_fetch_queue #(
        .LANES     (LANES),
        .DEPTH     (DEPTH),
        .DATA_W    (W),
        .NOP_INSTR (NOP)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_lane_valid  (in_lane_valid),
        .in_pc          (in_pc),
        .in_pc_plus1    (in_pc_plus1),
        .in_instr       (in_instr),
        .out_valid      (out_valid),
        .out_lane_valid (out_lane_valid),
        .out_pc         (out_pc),
        .out_pc_plus1   (out_pc_plus1),
        .out_instr      (out_instr),
        .out_consume    (out_consume),
        .count          (count)
    );

    always #5 clock = ~clock;

    // Model: a flat FIFO of lanes plus the lane count of each queued bundle.
    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] pcp1;
        logic [W-1:0] instr;
    } lane_t;

    lane_t m_lanes[$];
    int    m_n[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        int nin, k;
        bit do_push;
        if (reset || flush) begin
            m_lanes.delete();
            m_n.delete();
            return;
        end
        nin = 0;
        for (int i = 0; i < LANES; i++) nin += int'(in_lane_valid[i]);
        do_push = in_valid && (m_n.size() < DEPTH) && (nin > 0);
        if (m_n.size() > 0) begin
            k = (int'(out_consume) > LANES) ? LANES : int'(out_consume);
            if (k > m_n[0]) k = m_n[0];
            repeat (k) void'(m_lanes.pop_front());
            m_n[0] = m_n[0] - k;
            if (m_n[0] == 0) void'(m_n.pop_front());
        end
        if (do_push) begin
            for (int i = 0; i < nin; i++) begin
                m_lanes.push_back('{pc: in_pc[i*W +: W], pcp1: in_pc_plus1[i*W +: W],
                                    instr: in_instr[i*W +: W]});
            end
            m_n.push_back(nin);
        end
    endtask

    task automatic compare_all();
        logic [LANES-1:0]   e_lv;
        logic [LANES*W-1:0] e_pc, e_pcp1, e_instr;
        e_lv = '0;
        e_pc = '0;
        e_pcp1 = '0;
        for (int i = 0; i < LANES; i++) begin
            e_instr[i*W +: W] = NOP;
            if (m_n.size() > 0 && i < m_n[0]) begin
                e_lv[i]           = 1'b1;
                e_pc[i*W +: W]    = m_lanes[i].pc;
                e_pcp1[i*W +: W]  = m_lanes[i].pcp1;
                e_instr[i*W +: W] = m_lanes[i].instr;
            end
        end
        check_eq("out_valid", 64'(out_valid), 64'(m_n.size() > 0));
        check_eq("count", 64'(count), 64'(m_n.size()));
        check_eq("in_ready", 64'(in_ready), 64'(m_n.size() < DEPTH));
        check_eq("out_lane_valid", 64'(out_lane_valid), 64'(e_lv));
        check_eq("out_pc", 64'(out_pc), 64'(e_pc));
        check_eq("out_pc_plus1", 64'(out_pc_plus1), 64'(e_pcp1));
        check_eq("out_instr", 64'(out_instr), 64'(e_instr));
    endtask

    // One clock: inputs are already set; model follows the edge, outputs checked at negedge.
    task automatic tick();
        @(posedge clock);
        model_update();
        @(negedge clock);
        compare_all();
    endtask

    // Packed bundle of n lanes starting at PC base; instructions are random.
    task automatic set_bundle(input logic [W-1:0] base, input int n);
        in_lane_valid = '0;
        for (int i = 0; i < LANES; i++) begin
            in_lane_valid[i]     = (i < n);
            in_pc[i*W +: W]       = base + W'(i);
            in_pc_plus1[i*W +: W] = base + W'(i) + 1'b1;
            in_instr[i*W +: W]    = W'($urandom_range(0, 16'hFFFE));
        end
    endtask

    task automatic idle();
        reset = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_consume = '0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_consume = '0;
        set_bundle(16'h0, 0);
        @(negedge clock);

        // Reset for two cycles.
        tick();
        tick();
        check_eq("rst_instr", 64'(out_instr), 64'h0000_0000_FFFF_FFFF);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_ready", 64'(in_ready), 64'd1);
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        idle();
        tick();

        // Fill to DEPTH with decode stalled, then offer one more.
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b1;
            set_bundle(W'(16'h10 + 2 * b), 2);
            tick();
        end
        check_eq("full_count", 64'(count), 64'd4);
        check_eq("full_ready", 64'(in_ready), 64'd0);
        check_eq("full_head", 64'(out_pc), 64'h0000_0000_0011_0010);
        set_bundle(16'h18, 2);
        tick();
        check_eq("full_reject", 64'(count), 64'd4);
        idle();
        out_consume = 2'd2;
        repeat (4) tick();
        check_eq("drained", 64'(count), 64'd0);

        // Streaming push + pop every cycle across pointer wrap.
        idle();
        in_valid = 1'b1;
        set_bundle(16'h100, 2);
        tick();
        for (int b = 1; b <= 10; b++) begin
            in_valid = 1'b1;
            out_consume = 2'd2;
            set_bundle(W'(16'h100 + 2 * b), 2);
            tick();
            check_eq("stream_count", 64'(count), 64'd1);
            check_eq("stream_head", 64'(out_pc[W-1:0]), 64'(16'h100 + 2 * b));
        end
        idle();
        out_consume = 2'd2;
        tick();

        // Partial consume of head 0x20/0x21.
        idle();
        in_valid = 1'b1;
        set_bundle(16'h20, 2);
        tick();
        idle();
        out_consume = 2'd1;
        tick();
        check_eq("part_pc0", 64'(out_pc[W-1:0]), 64'h21);
        check_eq("part_lv", 64'(out_lane_valid), 64'b01);
        check_eq("part_instr1", 64'(out_instr[2*W-1:W]), 64'hFFFF);
        check_eq("part_count", 64'(count), 64'd1);
        tick();
        check_eq("part_pop", 64'(count), 64'd0);

        // Flush with a push in the same cycle.
        idle();
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            set_bundle(W'(16'h40 + 2 * b), 2);
            tick();
        end
        check_eq("pre_flush", 64'(count), 64'd3);
        flush = 1'b1;
        out_consume = 2'd2;
        set_bundle(16'h50, 2);
        tick();
        check_eq("flush_count", 64'(count), 64'd0);
        check_eq("flush_valid", 64'(out_valid), 64'd0);
        idle();
        tick();
        check_eq("flush_absent", 64'(out_valid), 64'd0);

        // All-invalid bundle: handshake but no storage.
        idle();
        in_valid = 1'b1;
        set_bundle(16'h60, 2);
        tick();
        set_bundle(16'h70, 0);
        check_eq("empty_ready", 64'(in_ready), 64'd1);
        tick();
        check_eq("empty_count", 64'(count), 64'd1);
        check_eq("empty_head", 64'(out_pc), 64'h0000_0000_0061_0060);

        // Random traffic, including consume > LANES, flush and reset.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 49) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            set_bundle(W'($urandom), int'($urandom_range(0, LANES)));
            out_consume = CW'($urandom_range(0, (1 << CW) - 1));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
